// File: rtl/mul_arb_4ch.sv
// mul_arb_4ch
//   Round-robin front end that shares one pipelined multiplier between
//   N_REQ requesters. One operation is granted per cycle and issued to the
//   multiplier on the following cycle. A tag pipeline follows each operation
//   through the multiplier, so every result is returned to the requester
//   that issued it, in issue order.
//
// Ports
//   clk, rst       clock (rising edge), synchronous active-high reset
//   arb_en         grants are allowed while high
//   req_valid      per-requester request
//   req_a, req_b   packed operands, requester i at [i*SIZE +: SIZE]
//   req_ready      one-hot grant (combinational)
//   mul_a, mul_b   registered operands to the multiplier
//   mul_en_in      registered issue strobe to the multiplier
//   mul_rst_n      multiplier reset (~rst)
//   mul_en_out     multiplier result valid
//   mul_out        multiplier product
//   rsp_valid      one-cycle response strobe
//   rsp_id         requester that owns the response
//   rsp_data       product returned with the response
//   inflight, idle count of issued, unreturned operations; idle when zero
//   err            sticky protocol error (result/tag misalignment)
module mul_arb_4ch #(
  parameter int N_REQ   = 4,
  parameter int SIZE    = 8,
  parameter int LATENCY = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arb_en,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ*SIZE-1:0]            req_a,
  input  logic [N_REQ*SIZE-1:0]            req_b,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [SIZE-1:0]                  mul_a,
  output logic [SIZE-1:0]                  mul_b,
  output logic                             mul_en_in,
  output logic                             mul_rst_n,
  input  logic                             mul_en_out,
  input  logic [2*SIZE-1:0]                mul_out,
  output logic                             rsp_valid,
  output logic [$clog2(N_REQ)-1:0]         rsp_id,
  output logic [2*SIZE-1:0]                rsp_data,
  output logic [$clog2(LATENCY+1)-1:0]     inflight,
  output logic                             idle,
  output logic                             err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(LATENCY + 1);

  logic [IDW-1:0]  ptr;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            xfer;
  logic [SIZE-1:0] sel_a;
  logic [SIZE-1:0] sel_b;

  // Tag pipeline: index 0 lines up with mul_en_in, index LATENCY with mul_en_out.
  logic [LATENCY:0] tag_vld_p;
  logic [IDW-1:0]   tag_id_p [LATENCY+1];

  logic head_vld;
  logic rsp_fire;

  assign mul_rst_n = ~rst;
  assign idle      = (inflight == '0);

  // Stage p0: round-robin grant, combinational from ptr and req_valid.
  // Scanning offsets from high to low lets the lowest offset from ptr win.
  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    if (arb_en && !rst) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % N_REQ;
        if (req_valid[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          grant_id   = IDW'(idx);
        end
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_a     = req_a[grant_id*SIZE +: SIZE];
  assign sel_b     = req_b[grant_id*SIZE +: SIZE];

  assign head_vld = tag_vld_p[LATENCY];
  assign rsp_fire = mul_en_out && head_vld;

  // Stage p1: issue registers, tag shift, response capture, bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      mul_en_in <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      tag_vld_p <= '0;
      for (int s = 0; s <= LATENCY; s++) tag_id_p[s] <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      inflight  <= '0;
      err       <= 1'b0;
    end else begin
      mul_en_in <= xfer;
      mul_a     <= xfer ? sel_a : '0;
      mul_b     <= xfer ? sel_b : '0;

      if (xfer) begin
        ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
      end

      tag_vld_p   <= {tag_vld_p[LATENCY-1:0], xfer};
      tag_id_p[0] <= grant_id;
      for (int s = 1; s <= LATENCY; s++) tag_id_p[s] <= tag_id_p[s-1];

      // An orphan result (no tag) produces no response, only err.
      rsp_valid <= rsp_fire;
      rsp_id    <= rsp_fire ? tag_id_p[LATENCY] : '0;
      rsp_data  <= rsp_fire ? mul_out : '0;

      if (mul_en_out != head_vld) err <= 1'b1;

      if (xfer && !rsp_fire)      inflight <= inflight + CW'(1);
      else if (!xfer && rsp_fire) inflight <= inflight - CW'(1);
    end
  end

endmodule

// File: tb/tb_mul_arb_4ch.sv
// tb_mul_arb_4ch
//   Directed bench for mul_arb_4ch with a behavioural LATENCY-stage
//   multiplier attached. Expected values are hand-computed constants.
module tb_mul_arb_4ch;

  localparam int N = 4;
  localparam int S = 8;
  localparam int L = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             arb_en;
  logic [N-1:0]     req_valid;
  logic [N*S-1:0]   req_a;
  logic [N*S-1:0]   req_b;
  logic [N-1:0]     req_ready;
  logic [S-1:0]     mul_a;
  logic [S-1:0]     mul_b;
  logic             mul_en_in;
  logic             mul_rst_n;
  logic             mul_en_out;
  logic [2*S-1:0]   mul_out;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [2*S-1:0]   rsp_data;
  logic [2:0]       inflight;
  logic             idle;
  logic             err;

  logic             orphan;

  always #5 clk = ~clk;

  mul_arb_4ch #(.N_REQ(N), .SIZE(S), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en_in(mul_en_in), .mul_rst_n(mul_rst_n),
    .mul_en_out(mul_en_out), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .inflight(inflight), .idle(idle), .err(err)
  );

  // Behavioural multiplier: LATENCY-cycle pipeline, cleared by mul_rst_n.
  logic [L-1:0]   en_p;
  logic [2*S-1:0] pr_p [L];

  always_ff @(posedge clk) begin
    if (!mul_rst_n) begin
      en_p <= '0;
      for (int i = 0; i < L; i++) pr_p[i] <= '0;
    end else begin
      en_p    <= {en_p[L-2:0], mul_en_in};
      pr_p[0] <= {8'h00, mul_a} * {8'h00, mul_b};
      for (int i = 1; i < L; i++) pr_p[i] <= pr_p[i-1];
    end
  end

  assign mul_en_out = en_p[L-1] | orphan;
  assign mul_out    = pr_p[L-1];

  // Response monitor.
  int          cyc = 0;
  int          q_id[$];
  logic [15:0] q_dat[$];
  int          q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      q_id.push_back(int'(rsp_id));
      q_dat.push_back(rsp_data);
      q_cyc.push_back(cyc);
    end
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*S +: S] = a;
    req_b[i*S +: S] = b;
  endtask

  task automatic clear_q();
    q_id.delete();
    q_dat.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    arb_en    = 1'b0;
    orphan    = 1'b0;
    ticks(2);
    rst = 1'b0;
    clear_q();
  endtask

  logic [15:0] rr_dat [4];

  initial begin
    rr_dat[0] = 16'd10;  // 1 * 10
    rr_dat[1] = 16'd22;  // 2 * 11
    rr_dat[2] = 16'd36;  // 3 * 12
    rr_dat[3] = 16'd52;  // 4 * 13

    // Reset state, with requests pending while rst is high.
    rst = 1'b1; arb_en = 1'b1; req_valid = 4'hF; orphan = 1'b0;
    req_a = '0; req_b = '0;
    @(negedge clk);
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_mul_en_in", 32'(mul_en_in), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mul_rst_n", 32'(mul_rst_n), 32'h0);
    rst = 1'b0; req_valid = '0; arb_en = 1'b0;
    #1;
    chk("mul_rst_n_rel", 32'(mul_rst_n), 32'h1);
    @(negedge clk);
    clear_q();

    // Single op from requester 2: 13 * 11 = 143, response 6 cycles later.
    arb_en = 1'b1;
    set_op(2, 8'd13, 8'd11);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) begin
        req_valid = '0;
        chk("single_en_in", 32'(mul_en_in), 32'h1);
        chk("single_mul_a", 32'(mul_a), 32'd13);
        chk("single_mul_b", 32'(mul_b), 32'd11);
        chk("single_inflight", 32'(inflight), 32'h1);
        chk("single_idle", 32'(idle), 32'h0);
      end
      if (k == 2) chk("single_en_in_off", 32'(mul_en_in), 32'h0);
      if (k == 5) chk("single_early", 32'(rsp_valid), 32'h0);
      if (k == 6) begin
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'd2);
        chk("single_rsp_data", 32'(rsp_data), 32'd143);
        chk("single_inflight_done", 32'(inflight), 32'h0);
        chk("single_idle_done", 32'(idle), 32'h1);
      end
      if (k == 7) begin
        chk("single_rsp_once", 32'(rsp_valid), 32'h0);
        chk("single_rsp_data_clr", 32'(rsp_data), 32'h0);
      end
    end
    clear_q();

    // Boundaries: 0xFF*0xFF from requester 3, then 0*0xA5 from requester 0.
    set_op(3, 8'hFF, 8'hFF);
    req_valid = 4'b1000;
    #1;
    chk("bnd_ready3", 32'(req_ready), 32'h8);
    tick();
    set_op(0, 8'h00, 8'hA5);
    req_valid = 4'b0001;
    #1;
    chk("bnd_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    ticks(8);
    chk("bnd_count", 32'(q_id.size()), 32'd2);
    if (q_id.size() == 2) begin
      chk("bnd_id0", 32'(q_id[0]), 32'd3);
      chk("bnd_dat0", 32'(q_dat[0]), 32'hFE01);
      chk("bnd_id1", 32'(q_id[1]), 32'd0);
      chk("bnd_dat1", 32'(q_dat[1]), 32'h0000);
      chk("bnd_gap", 32'(q_cyc[1] - q_cyc[0]), 32'd1);
    end

    // Round-robin with all four requesting from reset.
    do_reset();
    arb_en = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'(10 + i));
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_grant", 32'(1 << (k % 4)), 32'(req_ready));
      if (k == 5) chk("rr_inflight_peak", 32'(inflight), 32'd5);
      @(negedge clk);
    end
    req_valid = '0;
    ticks(10);
    chk("rr_count", 32'(q_id.size()), 32'd8);
    if (q_id.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("rr_id", 32'(q_id[k]), 32'(k % 4));
        chk("rr_dat", 32'(q_dat[k]), 32'(rr_dat[k % 4]));
        if (k > 0) chk("rr_gap", 32'(q_cyc[k] - q_cyc[k-1]), 32'd1);
      end
    end
    chk("rr_idle", 32'(idle), 32'h1);

    // arb_en drops with three operations in flight.
    do_reset();
    arb_en = 1'b1;
    req_valid = 4'hF;
    ticks(3);
    arb_en = 1'b0;
    #1;
    chk("arboff_ready", 32'(req_ready), 32'h0);
    chk("arboff_inflight", 32'(inflight), 32'd3);
    ticks(10);
    req_valid = '0;
    chk("arboff_count", 32'(q_id.size()), 32'd3);
    if (q_id.size() == 3) begin
      chk("arboff_id0", 32'(q_id[0]), 32'd0);
      chk("arboff_id1", 32'(q_id[1]), 32'd1);
      chk("arboff_id2", 32'(q_id[2]), 32'd2);
    end
    chk("arboff_inflight_end", 32'(inflight), 32'd0);
    chk("arboff_idle", 32'(idle), 32'h1);
    chk("arboff_err", 32'(err), 32'h0);
    clear_q();

    // Orphan result with an empty tag pipeline.
    orphan = 1'b1;
    tick();
    orphan = 1'b0;
    chk("orphan_err", 32'(err), 32'h1);
    chk("orphan_rsp", 32'(rsp_valid), 32'h0);
    ticks(3);
    chk("orphan_err_held", 32'(err), 32'h1);
    chk("orphan_no_rsp", 32'(q_id.size()), 32'd0);
    do_reset();
    chk("orphan_err_clr", 32'(err), 32'h0);

    // Reset with four operations in flight.
    arb_en = 1'b1;
    req_valid = 4'hF;
    ticks(4);
    chk("midrst_inflight", 32'(inflight), 32'd4);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    chk("midrst_inflight0", 32'(inflight), 32'd0);
    ticks(10);
    chk("midrst_no_rsp", 32'(q_id.size()), 32'd0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_idle", 32'(idle), 32'h1);
    req_valid = 4'hF;
    #1;
    chk("midrst_ptr0", 32'(req_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mul_arb_4ch.md
MUL_ARB_4CH -- requirements
Module: mul_arb_4ch

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters.
REQ-002 SHALL have parameter SIZE, default 8: operand width; product width 2*SIZE.
REQ-003 SHALL have parameter LATENCY, default 4: cycles from mul_en_in high to matching mul_en_out high.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port arb_en  input  1  grants allowed when high.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-008 SHALL have port req_a  input  N_REQ*SIZE  operand A, requester i at bits [i*SIZE +: SIZE].
REQ-009 SHALL have port req_b  input  N_REQ*SIZE  operand B, same packing.
REQ-010 SHALL have port req_ready  output  N_REQ  one-hot grant; a transfer is req_valid[i] & req_ready[i].
REQ-011 SHALL have ports mul_a, mul_b  output  SIZE each  operands to the shared multiplier.
REQ-012 SHALL have port mul_en_in  output  1  issue strobe to the multiplier.
REQ-013 SHALL have port mul_rst_n  output  1  multiplier reset, equal to ~rst (combinational).
REQ-014 SHALL have port mul_en_out  input  1  multiplier result-valid.
REQ-015 SHALL have port mul_out  input  2*SIZE  multiplier product.
REQ-016 SHALL have port rsp_valid  output  1  response strobe, one cycle per result.
REQ-017 SHALL have port rsp_id  output  clog2(N_REQ)  requester owning the response.
REQ-018 SHALL have port rsp_data  output  2*SIZE  product.
REQ-019 SHALL have ports inflight  output  clog2(LATENCY+1)  count of issued, unreturned operations; idle  output  1  high when inflight==0.
REQ-020 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-021 SHALL grant at most one requester per cycle; req_ready is combinational from req_valid, arb_en and the priority pointer.
REQ-022 SHALL use round-robin priority: search starts at pointer ptr, ascending with wrap; after a transfer to i, ptr becomes (i+1) mod N_REQ; with no transfer, ptr holds.
REQ-023 SHALL drive req_ready all-zero when arb_en low or no req_valid set; req_ready never depends on response state (no response backpressure).
REQ-024 SHALL register issue: in the cycle after a transfer to i, mul_en_in=1, mul_a/mul_b = requester i operands captured at transfer; otherwise mul_en_in=0, mul_a=mul_b=0.
REQ-025 SHALL carry a tag pipeline of LATENCY+1 stages (valid + id) aligned with mul_en_in so the head stage matches the cycle mul_en_out is sampled.
REQ-026 SHALL register response: the cycle after mul_en_out high with head tag valid, rsp_valid=1, rsp_id=head id, rsp_data=mul_out; otherwise rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-027 SHALL return responses in issue order; back-to-back issues each cycle SHALL yield back-to-back responses.
REQ-028 SHALL set err when mul_en_out high with head tag invalid, or head tag valid with mul_en_out low; err stays set until rst; no response is produced for an orphan mul_en_out.
REQ-029 SHALL update inflight: +1 on transfer, -1 on response, unchanged when both occur same cycle; count is from transfer to rsp_valid cycle inclusive of neither.
REQ-030 SHALL keep in-flight operations completing normally when arb_en drops.
REQ-031 SHALL keep total end-to-end latency transfer-to-rsp_valid = LATENCY+2 cycles.

Reset
REQ-032 SHALL, on rst high at a clock edge, clear ptr to 0, tag pipeline, inflight, err, mul_en_in, mul_a, mul_b, rsp_valid, rsp_id, rsp_data; idle=1.
REQ-033 SHALL drive req_ready all-zero while rst high.
REQ-034 SHALL discard all in-flight operations on reset mid-operation: no rsp_valid for them after rst deasserts, and no err raised.

Verification
REQ-035 Single op: requester 2 a=8'd13, b=8'd11, one transfer at cycle T -> rsp_valid at T+6, rsp_id=2, rsp_data=16'd143.
REQ-036 Round-robin: all four req_valid held high, arb_en=1 from reset -> grants 0,1,2,3,0,... one per cycle, responses same id order, no gaps.
REQ-037 Boundary: 8'hFF x 8'hFF from requester 3 -> rsp_data=16'hFE01; 0 x 8'hA5 -> 16'h0000.
REQ-038 arb_en low with three ops in flight -> req_ready=0, three responses still appear, inflight decrements to 0, idle=1.
REQ-039 Orphan: force mul_en_out high with empty tag pipeline -> err=1 next cycle, rsp_valid stays 0, err held until rst.
REQ-040 Reset mid-stream: rst for one cycle while 4 ops in flight -> no responses afterwards, inflight=0, ptr=0, err=0.
